// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared types and constants for the instruction-fetch queue
//
// Contents:
//   INSTR_W, ADDR_W   : instruction and address widths
//   ENTRY_W           : width of one queued entry {instr, pc}
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   fetch_state_e     : handshake state (IDLE, WAIT, DROP)
package ifetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // ST_WAIT keeps the response, ST_DROP discards it (request was overtaken
    // by a redirect while the memory was still working on it).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - DEPTH-entry synchronous FIFO with flush and fall-through head
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, push_data_i : write one entry at the tail
//   pop_i             : remove the head entry (ignored when empty)
//   flush_i           : empty the FIFO; wins over push and pop
//   head_o            : current head entry, zero when empty
//   count_o           : current occupancy
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q < DEPTH_C) || do_pop);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction fetch with req/ack memory port and redirect
//
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   mem_req_o, mem_addr_o         : fetch request and word-aligned address
//   mem_ack_i, mem_data_i         : memory response strobe and instruction word
//   redirect_i, redirect_pc_i     : flush and restart fetch at the target
//   instr_valid_o, instr_o        : head entry present, head instruction
//   instr_pc_o, instr_pc4_o       : head PC and head PC + 4
//   instr_ready_i                 : consumer pops the head
//   count_o                       : queue occupancy
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_data_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic [ADDR_W-1:0]  instr_pc4_o,
    input  logic               instr_ready_i,
    output logic [CNT_W-1:0]   count_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;          // address of the outstanding request
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;  // next address to issue from IDLE
    logic              mem_req_q;

    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   cnt_after;
    logic [ADDR_W-1:0]  redirect_tgt;
    logic               push;
    logic               pop;

    assign redirect_tgt = redirect_pc_i & ~32'd3;
    assign push         = (state_q == ST_WAIT) && mem_ack_i && !redirect_i;
    assign pop          = instr_valid_o && instr_ready_i;

    // Occupancy after an accepted response; a request is only outstanding in
    // WAIT while count < DEPTH, so count + 1 cannot overflow CNT_W.
    assign cnt_after = count + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_tgt;
                end else if (count < DEPTH_C) begin
                    state_d = ST_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = mem_ack_i ? ST_IDLE : ST_DROP;
                end else if (mem_ack_i) begin
                    fetch_pc_d = addr_q + 32'd4;
                    if (cnt_after < DEPTH_C) begin
                        // Back-to-back: next request goes out without an IDLE bubble.
                        addr_d = addr_q + 32'd4;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // addr_q stays on the stale request until the memory answers it.
                if (redirect_i) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= (state_d != ST_IDLE);
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i ({mem_data_i, addr_q}),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .count_o     (count)
    );

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = addr_q;
    assign count_o       = count;
    assign instr_valid_o = (count != '0);
    assign instr_o       = head[ENTRY_W-1:ADDR_W];
    assign instr_pc_o    = head[ADDR_W-1:0];
    assign instr_pc4_o   = instr_valid_o ? (head[ADDR_W-1:0] + 32'd4) : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             mem_req_o;
    logic [31:0]      mem_addr_o;
    logic             mem_ack_i = 1'b0;
    logic [31:0]      mem_data_i = '0;
    logic             redirect_i = 1'b0;
    logic [31:0]      redirect_pc_i = '0;
    logic             instr_valid_o;
    logic [31:0]      instr_o;
    logic [31:0]      instr_pc_o;
    logic [31:0]      instr_pc4_o;
    logic             instr_ready_i = 1'b0;
    logic [CNT_W-1:0] count_o;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_pc4_o   (instr_pc4_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Reference model: words the consumer must still receive, in order,
    // plus the address the next fresh request must carry.
    entry_t      exp_q[$];
    bit          live = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    bit          req_open = 1'b0;
    bit          stale = 1'b0;
    logic [31:0] open_addr = '0;
    int          pre_size = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares the head against the oldest expected word and pops on a handshake.
    always @(negedge clk) begin
        #1;
        if (live) begin
            pre_size = exp_q.size();
            chk("count", 32'(count_o), 32'(exp_q.size()));
            chk("valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                chk("empty_instr", instr_o, 32'h0);
                chk("empty_pc", instr_pc_o, 32'h0);
                chk("empty_pc4", instr_pc4_o, 32'h0);
            end else begin
                chk("head_instr", instr_o, exp_q[0].instr);
                chk("head_pc", instr_pc_o, exp_q[0].pc);
                chk("head_pc4", instr_pc4_o, exp_q[0].pc + 32'd4);
                if (instr_valid_o && instr_ready_i && !rst_i) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Predictor: follows the memory port and pushes words that must be delivered.
    always @(negedge clk) begin
        #2;
        if (rst_i) begin
            live     = 1'b1;
            exp_q.delete();
            exp_pc   = RESET_PC;
            req_open = 1'b0;
            stale    = 1'b0;
        end else if (live) begin
            if (mem_req_o) begin
                if (!req_open) begin
                    chk("req_addr", mem_addr_o, exp_pc);
                    chk("req_space", 32'(pre_size < DEPTH), 32'd1);
                end else begin
                    chk("addr_hold", mem_addr_o, open_addr);
                end
                if (mem_ack_i) begin
                    if (!redirect_i && !stale) begin
                        exp_q.push_back('{instr: mem_data_i, pc: mem_addr_o});
                        exp_pc = mem_addr_o + 32'd4;
                    end
                    stale    = 1'b0;
                    req_open = 1'b0;
                end else begin
                    req_open  = 1'b1;
                    open_addr = mem_addr_o;
                    if (redirect_i) stale = 1'b1;
                end
            end else begin
                if (req_open) chk("req_held", 32'(mem_req_o), 32'd1);
                req_open = 1'b0;
            end
            if (redirect_i) begin
                exp_q.delete();
                exp_pc = redirect_pc_i & ~32'd3;
            end
        end
    end

    task automatic cyc(input logic rst, input logic ack, input logic rdy,
                       input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        rst_i         = rst;
        mem_ack_i     = ack;
        mem_data_i    = $urandom;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Steps with ack low until a request is visible, then checks its address.
    task automatic wait_req(input string name, input logic rdy, input logic [31:0] addr);
        int k = 0;
        while (!mem_req_o && k < 10) begin
            cyc(1'b0, 1'b0, rdy, 1'b0, 32'h0);
            k++;
        end
        chk({name, "_seen"}, 32'(mem_req_o), 32'd1);
        chk({name, "_addr"}, mem_addr_o, addr);
    endtask

    initial begin
        // Streaming: ack in the first request cycle, consumer always ready.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1_req0", 32'(mem_req_o), 32'd0);
        chk("t1_valid0", 32'(instr_valid_o), 32'd0);
        chk("t1_cnt0", 32'(count_o), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1_req1", 32'(mem_req_o), 32'd1);
        chk("t1_addr1", mem_addr_o, 32'h0);
        for (int n = 2; n < 8; n++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("t1_valid", 32'(instr_valid_o), 32'd1);
            chk("t1_pc", instr_pc_o, 32'(4 * (n - 2)));
            chk("t1_pc4", instr_pc4_o, 32'(4 * (n - 2) + 4));
            chk("t1_addr", mem_addr_o, 32'(4 * (n - 1)));
        end

        // Fill to DEPTH with the consumer stalled, then free one slot.
        do_reset();
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t2_full_cnt", 32'(count_o), 32'd4);
        chk("t2_full_req", 32'(mem_req_o), 32'd0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t2_hold_cnt", 32'(count_o), 32'd4);
        chk("t2_hold_req", 32'(mem_req_o), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_req("t2_req", 1'b0, 32'h10);

        // Redirect in the second wait cycle of a slow fetch.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_req("t3_req", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        chk("t3_hold1", mem_addr_o, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t3_hold2_req", 32'(mem_req_o), 32'd1);
        chk("t3_hold2", mem_addr_o, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3_hold3", mem_addr_o, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t3_dropped", 32'(instr_valid_o), 32'd0);
        wait_req("t3_req2", 1'b1, 32'h100);
        mem_ack_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t3_first_valid", 32'(instr_valid_o), 32'd1);
        chk("t3_first_pc", instr_pc_o, 32'h100);

        // Redirect coinciding with ack and pop while three entries are queued.
        do_reset();
        begin
            int k = 0;
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            while (count_o != 3'd3 && k < 12) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
                k++;
            end
        end
        chk("t4_cnt3", 32'(count_o), 32'd3);
        chk("t4_req", 32'(mem_req_o), 32'd1);
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_cnt0", 32'(count_o), 32'd0);
        chk("t4_valid0", 32'(instr_valid_o), 32'd0);
        wait_req("t4_req2", 1'b0, 32'h200);

        // Address wrap at the top of the address space.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        wait_req("t5_req", 1'b1, 32'hFFFF_FFFC);
        mem_ack_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t5_wrap_addr", mem_addr_o, 32'h0);
        chk("t5_pc", instr_pc_o, 32'hFFFF_FFFC);
        chk("t5_pc4", instr_pc4_o, 32'h0);

        // Reset during an outstanding request; the late ack must be ignored.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_req("t6_req", 1'b1, 32'h0);
        rst_i = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6_req_after_rst", 32'(mem_req_o), 32'd0);
        chk("t6_cnt_after_rst", 32'(count_o), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6_cnt_ack_ignored", 32'(count_o), 32'd0);
        chk("t6_restart_addr", mem_addr_o, RESET_PC);

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 300) == 0, ($urandom % 10) < 4, ($urandom % 10) < 7,
                ($urandom % 25) == 0, ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
